// File: rtl/dcache_wt_ctrl_if.sv
// Bundle between the write-through data cache and its environment: the MEM-stage
// request/response side and the word-addressed data memory bus the cache initiates on.
interface dcache_wt_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
);
  logic [ADDR_W-1:0] cpu_adr;
  logic [WORD_W-1:0] cpu_wdata;
  logic              cpu_read;
  logic              cpu_write;
  logic [WORD_W-1:0] cpu_rdata;
  logic              stall;
  logic [ADDR_W-1:0] mem_adr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [WORD_W-1:0] mem_rdata;

  // The cache controller drives the memory bus and answers the pipeline.
  modport master (
    input  cpu_adr, cpu_wdata, cpu_read, cpu_write, mem_rdata,
    output cpu_rdata, stall, mem_adr, mem_wdata, mem_read, mem_write
  );

  modport slave (
    output cpu_adr, cpu_wdata, cpu_read, cpu_write, mem_rdata,
    input  cpu_rdata, stall, mem_adr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/dcache_wt_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with one-word
// lines; stalls the pipeline on read misses and on every store.
module dcache_wt_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int INDEX_BITS  = 6,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  dcache_wt_ctrl_if.master  bus
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS;
  localparam logic [3:0] LATENCY = 4'(MEM_LATENCY);

  typedef enum logic [1:0] {IDLE, RMISS, WRITE} state_t;

  state_t            state;
  state_t            state_next;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [WORD_W-1:0] data_arr [LINES];
  logic              done;
  logic              done_next;
  logic [3:0]        cnt;
  logic [3:0]        cnt_next;
  logic [ADDR_W-1:0] mem_adr;
  logic [ADDR_W-1:0] mem_adr_next;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_wdata_next;
  logic              mem_read;
  logic              mem_read_next;
  logic              mem_write;
  logic              mem_write_next;
  logic              fill_en;
  logic              update_en;

  logic [INDEX_BITS-1:0] index;
  logic [TAG_W-1:0]      tag;
  logic                  req;
  logic                  hit;
  logic                  read_only;

  assign index     = bus.cpu_adr[INDEX_BITS-1:0];
  assign tag       = bus.cpu_adr[ADDR_W-1:INDEX_BITS];
  assign req       = bus.cpu_read | bus.cpu_write;
  assign read_only = bus.cpu_read & ~bus.cpu_write;
  assign hit       = valid[index] && (tag_arr[index] == tag);

  // A read hit in IDLE is the only request that never freezes the pipeline;
  // done marks the cycle in which a finished miss or store is released.
  assign bus.stall     = (state != IDLE) ||
                         (req && !done && !(read_only && hit));
  assign bus.cpu_rdata = (state == IDLE && bus.cpu_read && hit) ? data_arr[index] : '0;

  assign bus.mem_adr   = mem_adr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      valid     <= '0;
      done      <= 1'b0;
      cnt       <= '0;
      mem_adr   <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      state     <= state_next;
      done      <= done_next;
      cnt       <= cnt_next;
      mem_adr   <= mem_adr_next;
      mem_wdata <= mem_wdata_next;
      mem_read  <= mem_read_next;
      mem_write <= mem_write_next;
      if (fill_en) valid[index] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; gating on rst drops a fill abandoned by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (fill_en) begin
        data_arr[index] <= bus.mem_rdata;
        tag_arr[index]  <= tag;
      end else if (update_en) begin
        data_arr[index] <= mem_wdata;
      end
    end
  end

  always_comb begin
    state_next     = state;
    done_next      = done;
    cnt_next       = cnt;
    mem_adr_next   = mem_adr;
    mem_wdata_next = mem_wdata;
    mem_read_next  = mem_read;
    mem_write_next = mem_write;
    fill_en        = 1'b0;
    update_en      = 1'b0;

    unique case (state)
      IDLE: begin
        if (done) begin
          done_next = 1'b0;
        end else if (bus.cpu_write) begin
          state_next     = WRITE;
          mem_write_next = 1'b1;
          mem_adr_next   = bus.cpu_adr;
          mem_wdata_next = bus.cpu_wdata;
        end else if (bus.cpu_read && !hit) begin
          state_next    = RMISS;
          mem_read_next = 1'b1;
          mem_adr_next  = bus.cpu_adr;
          cnt_next      = LATENCY;
        end
      end
      RMISS: begin
        cnt_next = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          fill_en       = 1'b1;
          mem_read_next = 1'b0;
          done_next     = 1'b1;
          state_next    = IDLE;
        end
      end
      WRITE: begin
        // Write-through: only refresh the copy when the line is already resident.
        update_en      = hit;
        mem_write_next = 1'b0;
        done_next      = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_wt_ctrl.sv
// Directed bench for the write-through data cache: a small word memory answers the
// cache's bus while each access is stepped until the stall drops.
module tb_dcache_wt_ctrl;

  logic clk;
  logic rst;
  int   check_count;
  int   error_count;
  int   overlap_count;

  logic [31:0] mem [0:1023];

  dcache_wt_ctrl_if #(.ADDR_W(32), .WORD_W(32)) bus ();

  dcache_wt_ctrl #(
    .ADDR_W(32), .WORD_W(32), .INDEX_BITS(6), .MEM_LATENCY(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns data while mem_read is held and commits stores at the clock edge.
  assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_adr[9:0]] : 32'd0;

  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_adr[9:0]] <= bus.mem_wdata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Presents one request and counts stall / bus cycles until the pipeline is released.
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] adr, input logic [31:0] wdata,
                               output int stall_cycles, output int read_cycles,
                               output int write_cycles, output logic [31:0] rdata,
                               output logic [31:0] last_adr, output logic [31:0] last_wdata);
    stall_cycles = 0;
    read_cycles  = 0;
    write_cycles = 0;
    last_adr     = 32'd0;
    last_wdata   = 32'd0;
    bus.cpu_adr   = adr;
    bus.cpu_wdata = wdata;
    bus.cpu_read  = rd;
    bus.cpu_write = wr;
    #1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (bus.mem_read && bus.mem_write) overlap_count++;
      if (bus.mem_read) begin
        read_cycles++;
        last_adr = bus.mem_adr;
      end
      if (bus.mem_write) begin
        write_cycles++;
        last_adr   = bus.mem_adr;
        last_wdata = bus.mem_wdata;
      end
      if (!bus.stall) break;
      stall_cycles++;
      if (cyc == 39) checkOutput("stall_timeout", 32'd1, 32'd0);
      @(negedge clk);
      #1;
    end
    rdata = bus.cpu_rdata;
    @(posedge clk);
    @(negedge clk);
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
  endtask

  int          st;
  int          rc;
  int          wc;
  logic [31:0] rdata;
  logic [31:0] ladr;
  logic [31:0] lwd;

  initial begin
    check_count   = 0;
    error_count   = 0;
    overlap_count = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i) ^ 32'h0000_A5A5;
    mem[250]  = 32'd20;
    mem[314]  = 32'd77;
    mem[1000] = 32'd7;
    mem[503]  = 32'd11;
    mem[378]  = 32'd55;
    mem[505]  = 32'd0;

    bus.cpu_adr   = 32'd0;
    bus.cpu_wdata = 32'd0;
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_stall",     {31'd0, bus.stall},     32'd0);
    checkOutput("reset_mem_read",  {31'd0, bus.mem_read},  32'd0);
    checkOutput("reset_mem_write", {31'd0, bus.mem_write}, 32'd0);
    checkOutput("reset_mem_adr",   bus.mem_adr,            32'd0);
    checkOutput("reset_mem_wdata", bus.mem_wdata,          32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Cold miss, then the repeated read hits
    applyStimulus(1'b1, 1'b0, 32'd250, 32'd0, st, rc, wc, rdata, ladr, lwd);
    checkOutput("cold_stall",   32'(st), 32'd3);
    checkOutput("cold_reads",   32'(rc), 32'd2);
    checkOutput("cold_adr",     ladr,    32'd250);
    checkOutput("cold_rdata",   rdata,   32'd20);
    applyStimulus(1'b1, 1'b0, 32'd250, 32'd0, st, rc, wc, rdata, ladr, lwd);
    checkOutput("hit_stall",    32'(st), 32'd0);
    checkOutput("hit_reads",    32'(rc), 32'd0);
    checkOutput("hit_rdata",    rdata,   32'd20);

    // 314 shares index 58 with 250
    applyStimulus(1'b1, 1'b0, 32'd314, 32'd0, st, rc, wc, rdata, ladr, lwd);
    checkOutput("conflict_stall", 32'(st), 32'd3);
    checkOutput("conflict_rdata", rdata,   32'd77);
    applyStimulus(1'b1, 1'b0, 32'd250, 32'd0, st, rc, wc, rdata, ladr, lwd);
    checkOutput("evicted_stall",  32'(st), 32'd3);
    checkOutput("evicted_reads",  32'(rc), 32'd2);
    checkOutput("evicted_rdata",  rdata,   32'd20);

    // Write hit updates both the cache line and memory
    applyStimulus(1'b1, 1'b0, 32'd1000, 32'd0, st, rc, wc, rdata, ladr, lwd);
    checkOutput("fill1000_rdata", rdata,   32'd7);
    applyStimulus(1'b0, 1'b1, 32'd1000, 32'd99, st, rc, wc, rdata, ladr, lwd);
    checkOutput("whit_stall",     32'(st), 32'd2);
    checkOutput("whit_writes",    32'(wc), 32'd1);
    checkOutput("whit_reads",     32'(rc), 32'd0);
    checkOutput("whit_adr",       ladr,    32'd1000);
    checkOutput("whit_wdata",     lwd,     32'd99);
    checkOutput("whit_memory",    mem[1000], 32'd99);
    applyStimulus(1'b1, 1'b0, 32'd1000, 32'd0, st, rc, wc, rdata, ladr, lwd);
    checkOutput("whit_read_stall", 32'(st), 32'd0);
    checkOutput("whit_read_reads", 32'(rc), 32'd0);
    checkOutput("whit_read_rdata", rdata,   32'd99);

    // Write miss does not allocate
    applyStimulus(1'b0, 1'b1, 32'd503, 32'd42, st, rc, wc, rdata, ladr, lwd);
    checkOutput("wmiss_stall",  32'(st), 32'd2);
    checkOutput("wmiss_writes", 32'(wc), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'd503, 32'd0, st, rc, wc, rdata, ladr, lwd);
    checkOutput("wmiss_read_stall", 32'(st), 32'd3);
    checkOutput("wmiss_read_reads", 32'(rc), 32'd2);
    checkOutput("wmiss_read_rdata", rdata,   32'd42);

    // Read and write together behave as a write
    applyStimulus(1'b1, 1'b1, 32'd505, 32'd5, st, rc, wc, rdata, ladr, lwd);
    checkOutput("both_stall",  32'(st), 32'd2);
    checkOutput("both_writes", 32'(wc), 32'd1);
    checkOutput("both_reads",  32'(rc), 32'd0);
    checkOutput("both_memory", mem[505], 32'd5);

    // Reset during the first RMISS cycle abandons the fill
    bus.cpu_adr  = 32'd378;
    bus.cpu_read = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("pre_reset_mem_read", {31'd0, bus.mem_read}, 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_mem_read", {31'd0, bus.mem_read}, 32'd0);
    checkOutput("midrst_stall",    {31'd0, bus.stall},    32'd1);
    @(negedge clk);
    bus.cpu_read = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'd250, 32'd0, st, rc, wc, rdata, ladr, lwd);
    checkOutput("postrst_stall", 32'(st), 32'd3);
    checkOutput("postrst_reads", 32'(rc), 32'd2);
    checkOutput("postrst_rdata", rdata,   32'd20);
    applyStimulus(1'b1, 1'b0, 32'd1000, 32'd0, st, rc, wc, rdata, ladr, lwd);
    checkOutput("postrst_invalid_stall", 32'(st), 32'd3);
    checkOutput("postrst_invalid_rdata", rdata,   32'd99);

    checkOutput("read_write_overlap", 32'(overlap_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
